// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: datapath widths and immediate-extension modes.
package mips_pkg;

  localparam int IMM_W  = 16;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    EXT_SIGN   = 2'd0,
    EXT_ZERO   = 2'd1,
    EXT_LUI    = 2'd2,
    EXT_BRANCH = 2'd3
  } ext_mode_e;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Immediate-stage bus: upstream immediate/handshake plus downstream result/handshake.
interface imm_extend_pipe_if
  import mips_pkg::*;
#(
  parameter int IN_W  = IMM_W,
  parameter int OUT_W = WORD_W,
  parameter int TAG_W = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_imm, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/imm_extend_comb.sv
// Combinational immediate extender: sign, zero, LUI and branch-offset modes.
module imm_extend_comb
  import mips_pkg::*;
#(
  parameter int IN_W  = IMM_W,
  parameter int OUT_W = WORD_W
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] ext
);

  if (OUT_W < 2 * IN_W) begin : g_width_check
    $error("imm_extend_comb: OUT_W must be >= 2*IN_W");
  end

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;

  assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
  assign zext = {{(OUT_W-IN_W){1'b0}}, imm};

  always_comb begin
    ext = sext;
    case (ext_mode_e'(mode))
      EXT_SIGN:   ext = sext;
      EXT_ZERO:   ext = zext;
      EXT_LUI:    ext = zext << IN_W;
      EXT_BRANCH: ext = sext << 2;
      default:    ext = sext;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered ID/EX immediate-extension stage with tag sideband and 2-entry skid buffer.
module imm_extend_pipe
  import mips_pkg::*;
#(
  parameter int IN_W  = IMM_W,
  parameter int OUT_W = WORD_W,
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  imm_extend_pipe_if.slave  bus
);

  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] main_data, skid_data;
  logic [TAG_W-1:0] main_tag, skid_tag;
  logic             main_v, skid_v, rdy_q;
  logic             main_v_n, skid_v_n;
  logic             ld_main_skid, ld_main_in, ld_skid;
  logic             accept, drain;

  imm_extend_comb #(.IN_W(IN_W), .OUT_W(OUT_W)) u_ext (
    .imm  (bus.in_imm),
    .mode (bus.in_mode),
    .ext  (ext)
  );

  assign accept = bus.in_valid && rdy_q;
  assign drain  = main_v && bus.out_ready;

  // Skid always has priority into main so the older item leaves first.
  always_comb begin
    main_v_n     = main_v;
    skid_v_n     = skid_v;
    ld_main_skid = 1'b0;
    ld_main_in   = 1'b0;
    ld_skid      = 1'b0;
    if (!main_v || drain) begin
      if (skid_v) begin
        ld_main_skid = 1'b1;
        main_v_n     = 1'b1;
        ld_skid      = accept;
        skid_v_n     = accept;
      end else begin
        ld_main_in = accept;
        main_v_n   = accept;
      end
    end else if (accept) begin
      ld_skid  = 1'b1;
      skid_v_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      rdy_q     <= 1'b1;
      main_data <= '0;
      main_tag  <= '0;
      skid_data <= '0;
      skid_tag  <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b1;
    end else begin
      main_v <= main_v_n;
      skid_v <= skid_v_n;
      rdy_q  <= !skid_v_n;
      if (ld_main_skid) begin
        main_data <= skid_data;
        main_tag  <= skid_tag;
      end else if (ld_main_in) begin
        main_data <= ext;
        main_tag  <= bus.in_tag;
      end
      if (ld_skid) begin
        skid_data <= ext;
        skid_tag  <= bus.in_tag;
      end
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = main_v;
  assign bus.out_data  = main_data;
  assign bus.out_tag   = main_tag;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: directed scenarios plus randomized traffic.
module tb_imm_extend_pipe;
  import mips_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [4:0] tag;
    int         cyc;
  } log_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   n_acc = 0;
  bit   strict = 1'b0;
  bit   prev_stall = 1'b0;
  bit   p3done = 1'b0;
  bit   sending = 1'b0;
  logic [31:0] held_data;
  logic [4:0]  held_tag;
  exp_t sb[$];
  log_t olog[$];

  imm_extend_pipe_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) bus ();
  imm_extend_pipe_if #(.IN_W(8), .OUT_W(16), .TAG_W(5)) bus8 ();

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus)
  );

  imm_extend_pipe #(.IN_W(8), .OUT_W(16), .TAG_W(5)) dut8 (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void chk(string nm, longint unsigned act, longint unsigned exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endfunction

  // Reference extension from the arithmetic meaning of each mode.
  function automatic longint ref_ext(longint imm, int mode, int in_w, int out_w);
    longint s, mask;
    s    = (imm >= (longint'(1) << (in_w - 1))) ? imm - (longint'(1) << in_w) : imm;
    mask = (longint'(1) << out_w) - 1;
    case (mode)
      0:       return s & mask;
      1:       return imm & mask;
      2:       return (imm * (longint'(1) << in_w)) & mask;
      default: return (s * 4) & mask;
    endcase
  endfunction

  task automatic send(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_imm   = imm;
    bus.in_mode  = mode;
    bus.in_tag   = tag;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.in_ready && !reset && !flush) begin
        sb.push_back('{data: 32'(ref_ext(longint'(imm), int'(mode), 16, 32)), tag: tag, cyc: cyc});
        n_acc++;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      $display("FAIL send_timeout: tag %0d never accepted, expected acceptance within 100 cycles", tag);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands an item downstream.
  always @(negedge clk) begin
    if (prev_stall) begin
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_data", bus.out_data, held_data);
      chk("hold_tag", bus.out_tag, held_tag);
    end
    prev_stall = 1'b0;
    if (!reset && !flush && bus.out_valid && !bus.out_ready) begin
      prev_stall = 1'b1;
      held_data  = bus.out_data;
      held_tag   = bus.out_tag;
    end
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_output: got tag %0d data 0x%0h, expected no output", bus.out_tag, bus.out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", bus.out_data, e.data);
        chk("out_tag", bus.out_tag, e.tag);
        if (strict) chk("latency_cycle", cyc, e.cyc + 1);
        olog.push_back('{tag: bus.out_tag, cyc: cyc});
      end
    end
  end

  initial begin
    logic [7:0]  imm8 [8];
    logic [1:0]  mode8 [8];
    int          base;
    bit          done;

    bus.in_valid = 0; bus.in_imm = '0; bus.in_mode = '0; bus.in_tag = '0; bus.out_ready = 1;
    bus8.in_valid = 0; bus8.in_imm = '0; bus8.in_mode = '0; bus8.in_tag = '0; bus8.out_ready = 1;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_out_data", bus.out_data, 0);
    chk("reset_out_tag", bus.out_tag, 0);

    // Back-to-back extension modes with exact 1-cycle latency.
    strict = 1'b1;
    send(16'h8000, EXT_SIGN, 5'd1);
    send(16'h8000, EXT_ZERO, 5'd2);
    send(16'h2000, EXT_SIGN, 5'd3);
    send(16'hFFFF, EXT_SIGN, 5'd4);
    send(16'h1234, EXT_LUI, 5'd5);
    send(16'hFFFF, EXT_BRANCH, 5'd6);
    send(16'h7FFF, EXT_BRANCH, 5'd7);
    repeat (2) step();
    chk("directed_drained", sb.size(), 0);
    strict = 1'b0;

    // Back-pressure: tags 1,2 fill the buffer, 3 waits.
    bus.out_ready = 0;
    base = n_acc;
    p3done = 0;
    fork
      begin
        send($urandom, EXT_SIGN, 5'd1);
        send($urandom, EXT_ZERO, 5'd2);
        send($urandom, EXT_LUI, 5'd3);
        p3done = 1;
      end
    join_none
    @(negedge clk);
    chk("first_accept_ready", bus.in_ready, 1);
    repeat (4) @(negedge clk);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_out_valid", bus.out_valid, 1);
    chk("full_out_tag", bus.out_tag, 1);
    chk("full_accepted", n_acc - base, 2);
    step();
    olog.delete();
    bus.out_ready = 1;
    done = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (p3done && sb.size() == 0) begin done = 1; break; end
    end
    chk("bp_drain_done", done, 1);
    step();
    chk("bp_count", olog.size(), 3);
    if (olog.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("bp_tag_order", olog[i].tag, i + 1);
      chk("bp_no_gap_1", olog[1].cyc, olog[0].cyc + 1);
      chk("bp_no_gap_2", olog[2].cyc, olog[1].cyc + 1);
    end

    // Flush with both entries full while offering tag 7.
    bus.out_ready = 0;
    send($urandom, EXT_SIGN, 5'd4);
    send($urandom, EXT_SIGN, 5'd5);
    flush = 1; bus.in_valid = 1; bus.in_tag = 5'd7; bus.in_imm = 16'h0777;
    step();
    flush = 0; bus.in_valid = 0;
    sb.delete();
    @(negedge clk);
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_in_ready", bus.in_ready, 1);
    step();
    bus.out_ready = 1;
    repeat (3) step();
    chk("flush_no_tag7", bus.out_valid, 0);

    // Flush coinciding with a drain: the drained item is consumed.
    bus.out_ready = 0;
    send(16'h0042, EXT_ZERO, 5'd10);
    flush = 1; bus.out_ready = 1;
    step();
    flush = 0;
    chk("flush_drain_consumed", sb.size(), 0);
    sb.delete();
    @(negedge clk);
    chk("flush_drain_valid", bus.out_valid, 0);
    step();

    // Reset mid-stream with main full.
    bus.out_ready = 0;
    send(16'hBEEF, EXT_SIGN, 5'd8);
    reset = 1;
    step();
    reset = 0;
    sb.delete();
    chk("midreset_out_valid", bus.out_valid, 0);
    chk("midreset_out_data", bus.out_data, 0);
    chk("midreset_out_tag", bus.out_tag, 0);
    chk("midreset_in_ready", bus.in_ready, 1);
    bus.out_ready = 1;
    strict = 1;
    send(16'hC001, EXT_BRANCH, 5'd9);
    repeat (2) step();
    strict = 0;

    // Randomized traffic with random downstream back-pressure.
    sending = 1;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 3) == 0) step();
          send(16'($urandom), 2'($urandom_range(0, 3)), 5'($urandom));
        end
        sending = 0;
      end
      begin
        while (sending) begin
          step();
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1;
    done = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (sb.size() == 0) begin done = 1; break; end
    end
    chk("random_drain_done", done, 1);
    step();

    // Narrow instance: IN_W=8, OUT_W=16.
    imm8[0] = 8'h80; mode8[0] = EXT_SIGN;
    imm8[1] = 8'hAB; mode8[1] = EXT_LUI;
    for (int i = 2; i < 8; i++) begin
      imm8[i] = 8'($urandom);
      mode8[i] = 2'($urandom_range(0, 3));
    end
    for (int i = 0; i < 8; i++) begin
      bus8.in_valid = 1; bus8.in_imm = imm8[i]; bus8.in_mode = mode8[i]; bus8.in_tag = 5'(i);
      @(negedge clk);
      chk("n8_in_ready", bus8.in_ready, 1);
      if (i > 0) begin
        chk("n8_out_valid", bus8.out_valid, 1);
        chk("n8_out_data", bus8.out_data, ref_ext(longint'(imm8[i-1]), int'(mode8[i-1]), 8, 16));
        chk("n8_out_tag", bus8.out_tag, i - 1);
      end
      step();
    end
    bus8.in_valid = 0;
    @(negedge clk);
    chk("n8_out_data_last", bus8.out_data, ref_ext(longint'(imm8[7]), int'(mode8[7]), 8, 16));
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Parametrised, registered immediate-extension stage for the ID/EX boundary of the pipelined MIPS core. It replaces the purely combinational 16-to-32 sign extender. It adds selectable extension modes (sign, zero, LUI, branch-offset), a tag that travels with each immediate, and a valid/ready handshake. A 2-entry skid buffer holds results so that hazard-unit back-pressure never drops an immediate.

Parameters:
IN_W, 16, immediate field width
OUT_W, 32, datapath width; must satisfy OUT_W >= 2*IN_W (elaboration error otherwise)
TAG_W, 5, sideband tag width (e.g. destination register number)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous pipeline flush (branch mispredict / exception)
in_valid  input  1  upstream presents an immediate
in_ready  output  1  stage can accept; registered
in_imm  input  IN_W  raw immediate field
in_mode  input  2  0=SIGN, 1=ZERO, 2=LUI, 3=BRANCH
in_tag  input  TAG_W  sideband, passed unchanged
out_valid  output  1  out_data/out_tag valid
out_ready  input  1  downstream accepts
out_data  output  OUT_W  extended immediate
out_tag  output  TAG_W  tag of the current out_data

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high, on port reset.
- Extension rules, computed combinationally on the input side:
  - SIGN: replicate in_imm[IN_W-1] into the upper bits.
  - ZERO: zero-fill the upper bits.
  - LUI: in_imm << IN_W, zero-filled above and below.
  - BRANCH: sign-extend, then << 2, discarding the top 2 bits.
- Storage: a main register (drives outputs) and a skid register, each with its own valid bit.
- Accept condition: in_valid && in_ready.
- Latency: 1 cycle from accept to out_valid=1. Throughput: 1 per cycle while out_ready=1.
- Drain condition: out_valid && out_ready. out_data/out_tag must stay stable while out_valid && !out_ready.
- Per-cycle update, evaluated in priority order:
  - reset: both valid bits = 0, out_data = 0, out_tag = 0, in_ready = 1. Any in-flight data is discarded. This applies mid-operation too.
  - flush: same clear as reset, except data registers may retain contents (don't-care while invalid). An input offered in the flush cycle is dropped even though in_ready=1. out_valid=0 in the next cycle.
  - main empty, or main draining:
    - if skid valid, skid moves to main;
    - else an accepted input loads main;
    - an accepted input while skid is valid loads skid (skid moves to main the same cycle).
  - main full and not draining: an accepted input loads skid.
- in_ready = !skid_valid, registered. It deasserts the cycle after the skid fills and reasserts the cycle after the skid empties.
- Order is strictly FIFO; no duplication or loss. Capacity is 2.
- Simultaneous accept and drain with skid empty: main is replaced; out_valid stays 1.
- Simultaneous flush and out_ready: the drained item counts as consumed by downstream. No new item appears.

Decomposition:
- Shared package (mips_pkg):
  - extend-mode constants EXT_SIGN, EXT_ZERO, EXT_LUI, EXT_BRANCH;
  - IMM_W=16 and WORD_W=32 defaults.
- One natural sub-module: imm_extend_comb, the pure combinational mode-select and extend, parametrised by IN_W/OUT_W. It replaces the old single-mode extender and is reusable in the EX forwarding path.
- The skid/handshake logic stays in the top module.

Test Plan:
- After reset, hold out_ready=1 and apply SIGN 0x8000, ZERO 0x8000, SIGN 0x2000, SIGN 0xFFFF on consecutive cycles.
  -> out_data is 0xFFFF8000, 0x00008000, 0x00002000, 0xFFFFFFFF, each 1 cycle after its accept, back-to-back.
- Apply LUI 0x1234, then BRANCH 0xFFFF, then BRANCH 0x7FFF.
  -> out_data is 0x12340000, 0xFFFFFFFC, 0x0001FFFC.
- Hold out_ready=0 and offer tags 1, 2, 3 continuously.
  -> In the 1st accept cycle after reset, in_ready=1. in_ready drops the cycle after the skid fills, so 1 and 2 are accepted and 3 waits.
  -> out_data stays stable on tag 1.
  -> Raise out_ready: out_tag sequence is 1, 2, 3, with no gaps after in_ready reasserts.
- With both entries full, assert flush for 1 cycle while offering tag 7.
  -> Next cycle out_valid=0 and in_ready=1; tag 7 never appears.
- Assert reset mid-stream (main full, out_ready=0).
  -> Next cycle out_valid=0, out_data=0, out_tag=0, in_ready=1. The first post-reset input emerges with 1-cycle latency.
- Re-elaborate with IN_W=8, OUT_W=16 and apply SIGN 0x80 and LUI 0xAB.
  -> out_data is 0xFF80 and 0xAB00.
